// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake, control and debug bundle for one pipeline-stage
//               register. The "up" signals face the producing stage and the
//               "dn" signals face the consuming stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic              up_ready;
  logic              dn_valid;
  logic [DATA_W-1:0] dn_data;
  logic              dn_ready;
  logic              stall;
  logic              flush;
  logic              clr_cnt;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Surrounding pipeline / hazard unit side
  modport master (
    output up_valid, up_data, dn_ready, stall, flush, clr_cnt,
    input  up_ready, dn_valid, dn_data, occ, stall_cnt, flush_cnt
  );

  // Stage register side
  modport slave (
    input  up_valid, up_data, dn_ready, stall, flush, clr_cnt,
    output up_ready, dn_valid, dn_data, occ, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline-stage register with valid/ready handshake,
//               stall (hold) and flush (kill), optional one-entry skid
//               buffer, and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  pipe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] w_m_data_nxt;
  logic [DATA_W-1:0] r_s_data;
  logic [DATA_W-1:0] w_s_data_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_m_valid;
  logic w_s_valid;
  logic w_ready;
  logic w_enq;
  logic w_deq;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_m_valid = (r_state != EMPTY);
  assign w_s_valid = (r_state == TWO);

  // With the skid entry, ready depends only on held state so the downstream
  // ready never ripples upstream; without it, ready looks through to ready_i.
  if (SKID != 0) begin : g_skid
    assign w_ready = !w_s_valid && !rst_i;
  end else begin : g_no_skid
    assign w_ready = !rst_i && (!w_m_valid || (bus.dn_ready && !bus.stall));
  end

  assign w_enq = bus.up_valid && w_ready;
  assign w_deq = w_m_valid && bus.dn_ready && !bus.stall;

  assign w_stall_inc = w_m_valid && (!bus.dn_ready || bus.stall);
  assign w_flush_inc = bus.flush && (w_m_valid || bus.up_valid);

  // State and payload registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= EMPTY;
      r_m_data <= '0;
      r_s_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_m_data <= w_m_data_nxt;
      r_s_data <= w_s_data_nxt;
    end
  end

  // Next-state: flush empties everything; otherwise a strict two-deep FIFO
  // where M is always the older beat and S only fills while M is blocked.
  always_comb begin
    w_state_nxt  = r_state;
    w_m_data_nxt = r_m_data;
    w_s_data_nxt = r_s_data;
    if (bus.flush) begin
      w_state_nxt  = EMPTY;
      w_m_data_nxt = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_enq) begin
            w_state_nxt  = ONE;
            w_m_data_nxt = bus.up_data;
          end
        end
        ONE: begin
          if (w_enq && w_deq) begin
            w_m_data_nxt = bus.up_data;
          end else if (w_enq) begin
            w_state_nxt  = TWO;
            w_s_data_nxt = bus.up_data;
          end else if (w_deq) begin
            w_state_nxt  = EMPTY;
            w_m_data_nxt = '0;
          end
        end
        TWO: begin
          if (w_deq) begin
            w_state_nxt  = ONE;
            w_m_data_nxt = r_s_data;
          end
        end
        default: begin
          w_state_nxt  = EMPTY;
          w_m_data_nxt = '0;
        end
      endcase
    end
  end

  // Saturating event counters; clear beats a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != C_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.up_ready  = w_ready;
  assign bus.dn_valid  = w_m_valid;
  assign bus.dn_data   = w_m_valid ? r_m_data : '0;
  assign bus.occ       = {1'b0, w_m_valid} + {1'b0, w_s_valid};
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg. Two instances share one
//               stimulus stream: SKID=1/CNT_W=16 and SKID=0/CNT_W=4 (the
//               narrow counter makes saturation reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        ready_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        clr_i = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL inst%0d %s at %0t: got %h, expected %h", inst, name, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SK = (gi == 0) ? 1 : 0;
    localparam int CW = (gi == 0) ? 16 : 4;
    localparam int CMAX = (1 << CW) - 1;

    pipe_stage_reg_if #(.DATA_W(64), .CNT_W(CW)) ifc ();

    assign ifc.up_valid = valid_i;
    assign ifc.up_data  = data_i;
    assign ifc.dn_ready = ready_i;
    assign ifc.stall    = stall_i;
    assign ifc.flush    = flush_i;
    assign ifc.clr_cnt  = clr_i;

    pipe_stage_reg #(.DATA_W(64), .SKID(SK), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc.slave)
    );

    // Reference model: beats accepted but not yet delivered, oldest first
    logic [63:0] q[$];
    int  exp_stall = 0;
    int  exp_flush = 0;
    bit  armed     = 1'b0;

    function automatic bit model_ready();
      if (rst) return 1'b0;
      if (SK != 0) return (q.size() < 2);
      return (q.size() == 0) || (ready_i && !stall_i);
    endfunction

    // Stimulus-side model update just before the active edge
    always @(negedge clk) begin
      bit enq;
      bit deq;
      #4;
      enq = valid_i && model_ready();
      deq = (q.size() != 0) && ready_i && !stall_i;
      if (rst) begin
        q.delete();
        exp_stall = 0;
        exp_flush = 0;
        armed = 1'b1;
      end else begin
        if (clr_i) begin
          exp_stall = 0;
          exp_flush = 0;
        end else begin
          if ((q.size() != 0) && (!ready_i || stall_i) && exp_stall < CMAX) exp_stall++;
          if (flush_i && ((q.size() != 0) || valid_i) && exp_flush < CMAX) exp_flush++;
        end
        if (flush_i) begin
          q.delete();
        end else begin
          if (deq) void'(q.pop_front());
          if (enq) q.push_back(data_i);
        end
      end
    end

    // Monitor: compare what the DUT presents against the model mid-cycle
    always @(negedge clk) begin
      if (armed) begin
        check("valid_o", gi, 64'(ifc.dn_valid), 64'(q.size() != 0));
        check("data_o", gi, ifc.dn_data, (q.size() != 0) ? q[0] : 64'h0);
        check("occ_o", gi, 64'(ifc.occ), 64'(q.size()));
        check("ready_o", gi, 64'(ifc.up_ready), 64'(model_ready()));
        check("stall_cnt_o", gi, 64'(ifc.stall_cnt), 64'(exp_stall));
        check("flush_cnt_o", gi, 64'(ifc.flush_cnt), 64'(exp_flush));
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r,
                      input logic s, input logic f, input logic c, input logic rs);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    stall_i = s;
    flush_i = f;
    clr_i   = c;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(0, 64'h0, 0, 0, 0, 0, 1);
    step(0, 64'h0, 0, 0, 0, 0, 1);
    // Streaming at full rate
    for (int k = 1; k <= 8; k++) step(1, 64'(k), 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // Downstream backpressure fills the skid entry
    step(1, 64'hA, 1, 0, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0, 0, 0);
    step(1, 64'hC, 0, 0, 0, 0, 0);
    step(1, 64'hC, 0, 0, 0, 0, 0);
    step(1, 64'hC, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // Hazard stall while upstream keeps offering
    step(1, 64'h5, 1, 0, 0, 0, 0);
    step(1, 64'h6, 1, 1, 0, 0, 0);
    step(1, 64'h6, 1, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // Flush with full stage and an incoming beat
    step(1, 64'h11, 0, 0, 0, 0, 0);
    step(1, 64'h22, 0, 0, 0, 0, 0);
    step(1, 64'h33, 0, 0, 1, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // SKID=0 look-through: toggle ready_i with valid_i held high
    for (int k = 0; k < 8; k++) step(1, 64'(16'h100 + k), k[0], 0, 0, 0, 0);
    // Reset mid-transfer, then flush and reset together
    step(1, 64'h77, 0, 0, 0, 0, 0);
    step(1, 64'h78, 0, 0, 0, 0, 1);
    step(1, 64'h79, 0, 0, 0, 0, 0);
    step(1, 64'h7A, 0, 0, 1, 0, 1);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // Long stall: saturates the narrow counter, then clear mid-stall
    step(1, 64'hDEAD, 1, 0, 0, 0, 0);
    for (int k = 0; k < 24; k++) step(0, 64'h0, 1, 1, 0, 0, 0);
    step(0, 64'h0, 1, 1, 0, 1, 0);
    step(0, 64'h0, 1, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 7,
           {$urandom, $urandom},
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register, the general successor of the fixed IF/ID latch. It carries a DATA_W-bit payload (e.g. {pc, instr}) between two pipeline stages with a valid/ready handshake, hold (stall) and kill (flush) controls, and an optional one-entry skid buffer so that ready does not propagate combinationally upstream. Saturating stall/flush event counters feed the hazard-unit debug path. One instance sits at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 64: payload width in bits.
- SKID, 1: 1 = two-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o.
- CNT_W, 16: width of each event counter.

- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  upstream beat valid
- data_i  in  DATA_W  upstream payload
- ready_o  out  1  stage can accept a beat
- valid_o  out  1  downstream beat valid
- data_o  out  DATA_W  downstream payload
- ready_i  in  1  downstream can accept
- stall_i  in  1  hazard hold; blocks dequeue only
- flush_i  in  1  kill all held and incoming beats
- clr_cnt_i  in  1  synchronous clear of both counters
- occ_o  out  2  entries held (0..2)
- stall_cnt_o  out  CNT_W  stall-cycle count
- flush_cnt_o  out  CNT_W  effective-flush count

## Operation
- Storage: main entry M (drives data_o) and, when SKID=1, skid entry S. States: EMPTY (occ 0), ONE (M valid), TWO (M and S valid; SKID=1 only).
- enq = valid_i && ready_o; deq = valid_o && ready_i && !stall_i.
- ready_o: SKID=1 → !S_valid && !rst_i (registered state only). SKID=0 → !rst_i && (!M_valid || (ready_i && !stall_i)).
- Transitions (flush_i=0): EMPTY + enq → ONE, M=data_i. ONE + enq + deq → ONE, M=data_i. ONE + enq only → TWO, S=data_i. ONE + deq only → EMPTY. TWO + deq → ONE, M=S. Otherwise hold. Strict FIFO order.
- stall_i: valid_o and data_o held unchanged; enqueue still allowed while ready_o=1.
- flush_i (priority over everything except rst_i): M and S invalidated, next state EMPTY; a beat handshaken in the same cycle is discarded (upstream treats it as accepted). No beat is emitted downstream that cycle only if the held beat was not dequeued; deq in the flush cycle still counts as delivered.
- data_o = 0 whenever valid_o = 0 (bubble = all-zero NOP); M payload cleared on reset, flush and transition to EMPTY.
- valid_o = M_valid. occ_o = M_valid + S_valid.
- stall_cnt_o +1 each cycle valid_o && (!ready_i || stall_i).
- flush_cnt_o +1 each cycle flush_i && (occ_o != 0 || valid_i).
- Counters saturate at 2^CNT_W−1; clr_cnt_i zeroes both and wins over a same-cycle increment.

## Timing
- Reset (rst_i high at edge): valid_o=0, data_o=0, occ_o=0, counters=0, S invalid; ready_o=0 while rst_i high, 1 in the first cycle after.
- Latency: beat accepted at edge N appears on data_o/valid_o after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle with ready_i=1, stall_i=0, both modes.
- SKID=1: no combinational path ready_i→ready_o; after one downstream stall cycle ready_o drops one cycle later (S absorbs the in-flight beat).
- SKID=0: ready_o follows ready_i/stall_i in the same cycle.
- rst_i mid-transfer: all state discarded at that edge, no beat emitted afterward.
- flush_i + rst_i together: reset behaviour; flush_cnt_o not incremented.

## Test plan
- Reset then stream 0x1..0x8 with ready_i=1, SKID=1 → data_o 0x1..0x8 on consecutive cycles, 1-cycle latency, occ_o=1 throughout, stall_cnt_o=0.
- SKID=1, stream 0xA,0xB,0xC, ready_i=0 for 3 cycles after 0xA appears → occ_o=2, ready_o=0 from the cycle after 0xB enters; on ready_i=1 order 0xA,0xB,0xC, no loss or duplicate, stall_cnt_o=3.
- stall_i=1 for 2 cycles with 0x5 held and valid_i=1 carrying 0x6 → data_o stays 0x5, 0x6 goes into S, then 0x5,0x6 delivered in order; stall_cnt_o=2.
- occ_o=2 (0x11,0x22) and valid_i=1 with 0x33, pulse flush_i → next cycle valid_o=0, data_o=0, occ_o=0, flush_cnt_o=1; 0x33 never appears.
- SKID=0: valid_i=1 constantly, toggle ready_i each cycle → ready_o equals ready_i||!valid_o combinationally, occ_o never exceeds 1.
- stall_cnt_o at 0xFFFF (CNT_W=16) with continued stalls → holds 0xFFFF; clr_cnt_i during a stall → 0 next cycle.
